// File: rtl/stopwatch_pkg.sv
// rtl/stopwatch_pkg.sv - shared state enum and default parameters for the stopwatch stage
package stopwatch_pkg;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        PAUSED = 2'd1,
        SLEEP  = 2'd2
    } state_t;

    localparam int DEFAULT_MODULO      = 60;
    localparam int DEFAULT_WIDTH       = 6;
    localparam int DEFAULT_THRESHOLD   = 30;
    localparam int DEFAULT_IDLE_CYCLES = 30;

endpackage

// File: rtl/idle_timer.sv
// rtl/idle_timer.sv - counts consecutive paused cycles and flags when sleep is due
module idle_timer
    import stopwatch_pkg::*;
#(
    parameter int IDLE_CYCLES = DEFAULT_IDLE_CYCLES
) (
    input  logic clk,
    input  logic reset,
    input  logic inc,
    input  logic clr,
    output logic expired
);

    localparam int CW = $clog2(IDLE_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(IDLE_CYCLES - 1);

    if (IDLE_CYCLES < 1) begin : g_bad_idle
        $error("idle_timer: IDLE_CYCLES must be at least 1");
    end

    logic [CW-1:0] idle_count;

    // Idle count register; clr wins over inc so a wake-up or load always restarts from zero.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            idle_count <= '0;
        end else if (clr) begin
            idle_count <= '0;
        end else if (inc) begin
            idle_count <= idle_count + 1'b1;
        end
    end

    assign expired = (idle_count == LAST);

endmodule

// File: rtl/stopwatch_counter_stage.sv
// rtl/stopwatch_counter_stage.sv - cascadable modulo counter stage with pause and idle sleep
module stopwatch_counter_stage
    import stopwatch_pkg::*;
#(
    parameter int MODULO      = DEFAULT_MODULO,
    parameter int WIDTH       = DEFAULT_WIDTH,
    parameter int THRESHOLD   = DEFAULT_THRESHOLD,
    parameter int IDLE_CYCLES = DEFAULT_IDLE_CYCLES
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en_tick,
    input  logic             pause,
    input  logic             down,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic             carry,
    output logic             at_threshold,
    output logic             power_save
);

    if (MODULO > (2 ** WIDTH)) begin : g_bad_width
        $error("stopwatch_counter_stage: MODULO does not fit in WIDTH bits");
    end

    if (MODULO < 2) begin : g_bad_modulo
        $error("stopwatch_counter_stage: MODULO must be at least 2");
    end

    localparam logic [WIDTH-1:0] TOP  = WIDTH'(MODULO - 1);
    localparam logic [WIDTH-1:0] TH_W = WIDTH'(THRESHOLD);
    localparam bit TH_REACHABLE = (THRESHOLD >= 0) && (THRESHOLD < MODULO);

    state_t           state;
    state_t           next_state;
    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;
    logic [WIDTH-1:0] load_sat;
    logic             count_en;
    logic             is_top;
    logic             is_bottom;
    logic             power_save_q;
    logic             idle_inc;
    logic             idle_clr;
    logic             idle_expired;

    idle_timer #(
        .IDLE_CYCLES (IDLE_CYCLES)
    ) u_idle_timer (
        .clk     (clk),
        .reset   (reset),
        .inc     (idle_inc),
        .clr     (idle_clr),
        .expired (idle_expired)
    );

    assign count_en  = (state == RUN) && !pause && en_tick;
    assign is_top    = (count_q == TOP);
    assign is_bottom = (count_q == '0);
    assign load_sat  = (load_val > TOP) ? TOP : load_val;

    // Wrap strobe for the next stage; suppressed when clear/load overrides the count.
    assign carry = count_en && !clear && !load && (down ? is_bottom : is_top);

    assign at_threshold = TH_REACHABLE && (count_q == TH_W);
    assign count        = count_q;
    assign power_save   = power_save_q;

    // Count datapath: clear beats load beats counting; direction is sampled on the counting edge.
    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (load) begin
            count_d = load_sat;
        end else if (count_en) begin
            if (down) begin
                count_d = is_bottom ? TOP : (count_q - 1'b1);
            end else begin
                count_d = is_top ? '0 : (count_q + 1'b1);
            end
        end
    end

    // Next-state logic and idle-timer control for RUN / PAUSED / SLEEP.
    always_comb begin
        next_state = state;
        idle_inc   = 1'b0;
        idle_clr   = 1'b0;
        case (state)
            RUN: begin
                if (pause) begin
                    next_state = PAUSED;
                    idle_clr   = 1'b1;
                end
            end
            PAUSED: begin
                if (!pause) begin
                    next_state = RUN;
                    idle_clr   = 1'b1;
                end else if (clear || load) begin
                    idle_clr   = 1'b1;
                end else if (idle_expired) begin
                    next_state = SLEEP;
                    idle_clr   = 1'b1;
                end else begin
                    idle_inc   = 1'b1;
                end
            end
            SLEEP: begin
                if (!pause) begin
                    next_state = RUN;
                    idle_clr   = 1'b1;
                end else if (clear || load) begin
                    next_state = PAUSED;
                    idle_clr   = 1'b1;
                end
            end
            default: begin
                next_state = RUN;
                idle_clr   = 1'b1;
            end
        endcase
    end

    // Single registered stage for state, count and the power-save flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= RUN;
            count_q      <= '0;
            power_save_q <= 1'b0;
        end else begin
            state        <= next_state;
            count_q      <= count_d;
            power_save_q <= (next_state == SLEEP);
        end
    end

endmodule

// File: tb/tb_stopwatch_counter_stage.sv
// tb/tb_stopwatch_counter_stage.sv - vector, sequence and randomized checks of stopwatch_counter_stage
module tb_stopwatch_counter_stage;

    localparam int MODULO      = 60;
    localparam int WIDTH       = 6;
    localparam int THRESHOLD   = 30;
    localparam int IDLE_CYCLES = 30;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             en_tick = 1'b0;
    logic             pause = 1'b0;
    logic             down = 1'b0;
    logic             clear = 1'b0;
    logic             load = 1'b0;
    logic [WIDTH-1:0] load_val = '0;
    logic [WIDTH-1:0] count;
    logic             carry;
    logic             at_threshold;
    logic             power_save;

    stopwatch_counter_stage #(
        .MODULO      (MODULO),
        .WIDTH       (WIDTH),
        .THRESHOLD   (THRESHOLD),
        .IDLE_CYCLES (IDLE_CYCLES)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .en_tick      (en_tick),
        .pause        (pause),
        .down         (down),
        .clear        (clear),
        .load         (load),
        .load_val     (load_val),
        .count        (count),
        .carry        (carry),
        .at_threshold (at_threshold),
        .power_save   (power_save)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model: count as plain integer, activity as paused/sleeping flags plus
    // the number of consecutive paused cycles already spent.
    int m_count;
    bit m_paused;
    bit m_sleep;
    int m_paused_cycles;

    typedef struct {
        logic       clr;
        logic       ld;
        logic [5:0] lv;
        logic       en;
        logic       p;
        logic       dn;
        int         exp_carry;
        int         exp_count;
        int         exp_thr;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic c, input logic l, input int lv, input logic e,
                                input logic p, input logic d, input int ec, input int ecnt,
                                input int et);
        vec_t v;
        v.clr = c; v.ld = l; v.lv = 6'(lv); v.en = e; v.p = p; v.dn = d;
        v.exp_carry = ec; v.exp_count = ecnt; v.exp_thr = et;
        return v;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_count         = 0;
        m_paused        = 1'b0;
        m_sleep         = 1'b0;
        m_paused_cycles = 0;
    endtask

    function automatic int model_carry();
        bit running;
        running = !m_paused && !m_sleep;
        if (!running || pause || !en_tick || clear || load) return 0;
        if (down) return (m_count == 0) ? 1 : 0;
        return ((m_count + 1) == MODULO) ? 1 : 0;
    endfunction

    task automatic model_step();
        bit running;
        int lv;
        running = !m_paused && !m_sleep;
        lv = int'(load_val);
        if (clear) m_count = 0;
        else if (load) m_count = (lv >= MODULO) ? MODULO - 1 : lv;
        else if (running && !pause && en_tick)
            m_count = down ? (m_count + MODULO - 1) % MODULO : (m_count + 1) % MODULO;

        if (running) begin
            if (pause) begin
                m_paused = 1'b1;
                m_paused_cycles = 0;
            end
        end else if (m_paused) begin
            if (!pause) begin
                m_paused = 1'b0;
            end else if (clear || load) begin
                m_paused_cycles = 0;
            end else if (m_paused_cycles + 1 >= IDLE_CYCLES) begin
                m_paused = 1'b0;
                m_sleep  = 1'b1;
            end else begin
                m_paused_cycles++;
            end
        end else begin
            if (!pause) begin
                m_sleep = 1'b0;
            end else if (clear || load) begin
                m_sleep = 1'b0;
                m_paused = 1'b1;
                m_paused_cycles = 0;
            end
        end
    endtask

    task automatic set_in(input logic c, input logic l, input int lv, input logic e,
                          input logic p, input logic d);
        clear = c; load = l; load_val = 6'(lv); en_tick = e; pause = p; down = d;
    endtask

    // Called at a falling edge with inputs applied: checks outputs, advances model, one clock.
    task automatic cycle(input string tag);
        #1;
        chk({tag, " carry"}, int'(carry), model_carry());
        chk({tag, " count"}, int'(count), m_count);
        chk({tag, " at_threshold"}, int'(at_threshold), (m_count == THRESHOLD) ? 1 : 0);
        chk({tag, " power_save"}, int'(power_save), m_sleep ? 1 : 0);
        model_step();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        vecs.push_back(mk(0, 1, 58, 0, 0, 0, 0, 58, 0));
        vecs.push_back(mk(0, 0,  0, 1, 0, 0, 0, 59, 0));
        vecs.push_back(mk(0, 0,  0, 1, 0, 0, 1,  0, 0));
        vecs.push_back(mk(0, 0,  0, 1, 0, 0, 0,  1, 0));
        vecs.push_back(mk(0, 0,  0, 1, 0, 1, 0,  0, 0));
        vecs.push_back(mk(0, 0,  0, 1, 0, 1, 1, 59, 0));
        vecs.push_back(mk(1, 1, 10, 1, 0, 0, 0,  0, 0));
        vecs.push_back(mk(0, 1, 63, 0, 0, 0, 0, 59, 0));
        vecs.push_back(mk(0, 1, 63, 1, 0, 0, 0, 59, 0));
        vecs.push_back(mk(0, 0,  0, 1, 0, 0, 1,  0, 0));
        vecs.push_back(mk(0, 1, 30, 0, 0, 0, 0, 30, 1));
        vecs.push_back(mk(0, 0,  0, 1, 0, 1, 0, 29, 0));
        vecs.push_back(mk(0, 0,  0, 1, 0, 0, 0, 30, 1));
        vecs.push_back(mk(0, 1, 60, 0, 0, 0, 0, 59, 0));
        vecs.push_back(mk(1, 0,  0, 1, 0, 0, 0,  0, 0));
        vecs.push_back(mk(0, 1, 30, 0, 0, 0, 0, 30, 1));

        // Reset state while reset is held low.
        model_reset();
        #1;
        chk("reset count", int'(count), 0);
        chk("reset power_save", int'(power_save), 0);
        chk("reset carry", int'(carry), 0);
        chk("reset at_threshold", int'(at_threshold), 0);
        @(negedge clk);
        reset = 1'b1;

        // Directed vectors: wrap, borrow, priority, saturation, direction change.
        foreach (vecs[i]) begin
            set_in(vecs[i].clr, vecs[i].ld, int'(vecs[i].lv), vecs[i].en, vecs[i].p, vecs[i].dn);
            #1;
            chk($sformatf("vec%0d carry", i), int'(carry), vecs[i].exp_carry);
            cycle($sformatf("vec%0d", i));
            chk($sformatf("vec%0d count", i), int'(count), vecs[i].exp_count);
            chk($sformatf("vec%0d at_threshold", i), int'(at_threshold), vecs[i].exp_thr);
        end

        // Sleep entry: one edge to PAUSED, then IDLE_CYCLES more edges to SLEEP.
        set_in(0, 0, 0, 1, 1, 0);
        cycle("pause");
        chk("paused power_save", int'(power_save), 0);
        chk("paused holds count", int'(count), 30);
        repeat (IDLE_CYCLES - 1) cycle("idle");
        chk("pre-sleep power_save", int'(power_save), 0);
        cycle("idle");
        chk("sleep entry power_save", int'(power_save), 1);

        // Load while sleeping with pause held: back to PAUSED, idle restarts.
        set_in(0, 1, 30, 0, 1, 0);
        cycle("sleep load");
        chk("sleep load count", int'(count), 30);
        chk("sleep load at_threshold", int'(at_threshold), 1);
        chk("sleep load power_save", int'(power_save), 0);
        set_in(0, 0, 0, 0, 1, 0);
        repeat (IDLE_CYCLES - 1) cycle("reidle");
        chk("re-sleep early power_save", int'(power_save), 0);
        cycle("reidle");
        chk("re-sleep power_save", int'(power_save), 1);

        // Wake from sleep.
        set_in(0, 0, 0, 1, 0, 0);
        cycle("wake");
        chk("wake power_save", int'(power_save), 0);
        chk("wake holds count", int'(count), 30);

        // Go back to sleep, then assert reset asynchronously mid-sleep.
        set_in(0, 0, 0, 0, 1, 0);
        repeat (IDLE_CYCLES + 1) cycle("sleep2");
        chk("sleep2 power_save", int'(power_save), 1);
        #2;
        reset = 1'b0;
        #1;
        chk("async reset count", int'(count), 0);
        chk("async reset power_save", int'(power_save), 0);
        chk("async reset at_threshold", int'(at_threshold), 0);
        model_reset();
        @(negedge clk);
        reset = 1'b1;
        set_in(0, 0, 0, 1, 0, 0);
        cycle("post reset");
        chk("post reset first tick", int'(count), 1);

        // Randomized stimulus against the reference model.
        set_in(0, 0, 0, 0, 0, 0);
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(59, 0) == 0) pause = ~pause;
            if ($urandom_range(7, 0) == 0) down = ~down;
            en_tick  = 1'($urandom_range(1, 0));
            clear    = ($urandom_range(39, 0) == 0);
            load     = ($urandom_range(24, 0) == 0);
            load_val = 6'($urandom_range(63, 0));
            cycle("rnd");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
